// File: rtl/image_proc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// image_proc_ctrl_pkg
// Shared definitions for the image-processing run controller:
//   - algorithm codes driven to the datapath (NN / PR / DC / BA)
//   - controller FSM state encodings
//   - ERR_CODE values reported to the host
//   - watchdog counter width and an algorithm-support helper
// No ports (package).
// -----------------------------------------------------------------------------
package image_proc_ctrl_pkg;

    typedef enum logic [1:0] {
        ALG_NN = 2'd0,
        ALG_PR = 2'd1,
        ALG_DC = 2'd2,
        ALG_BA = 2'd3
    } alg_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_CPLT = 3'd3,
        ST_FAIL = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_UNSUP   = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_RSVD    = 2'd3
    } err_e;

    localparam int WD_WIDTH = 20;

    // True when the datapath build implements the requested algorithm code.
    function automatic logic alg_supported(input logic [3:0] mask, input logic [1:0] code);
        return mask[code];
    endfunction

endpackage

// File: rtl/image_proc_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// ipc_watchdog
// Counts cycles while enabled and flags expiry on the LIMIT-th enabled cycle
// since the last clear.  Only built when IPC_TIMEOUT_EN is defined.
// Ports:
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   clear_i   : synchronous clear of the cycle count (has priority)
//   enable_i  : count this cycle
//   expire_o  : high during the LIMIT-th enabled cycle (combinational)
// -----------------------------------------------------------------------------
module ipc_watchdog
    import image_proc_ctrl_pkg::*;
#(
    parameter logic [WD_WIDTH-1:0] LIMIT = 20'd1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [WD_WIDTH-1:0] LAST = LIMIT - 20'd1;

    logic [WD_WIDTH-1:0] count_q;
    logic [WD_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            // Saturate rather than wrap so a missed expiry can never re-arm.
            count_d = count_q + 20'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of enabled cycles already completed, so the
    // LIMIT-th cycle is the one where it equals LIMIT-1.
    assign expire_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/image_proc_ctrl.sv
// -----------------------------------------------------------------------------
// image_proc_ctrl
// Run controller for the existing image_processing datapath.  Holds the
// datapath in reset, latches the host's algorithm code, releases the datapath
// after ARM_CYCLES of arming, waits for ENG_DONE and reports DONE or ERROR
// until the host acknowledges.  Contains no datapath logic.
//
// Optional feature: define IPC_TIMEOUT_EN to add a RUN-state watchdog
// (ipc_watchdog) that fails the run with ERR_CODE=2 after TIMEOUT_CYCLES.
// Without it RUN waits for ENG_DONE indefinitely.
//
// Ports:
//   CLK        in   clock
//   RESET      in   asynchronous active-high reset
//   START      in   host start (pulse or level), sampled in IDLE only
//   ALGORITHM  in 2 host algorithm code (0 NN, 1 PR, 2 DC, 3 BA)
//   ACK        in   host acknowledge, clears DONE / ERROR
//   ENG_DONE   in   datapath done flag
//   ENG_RESET  out  reset to the datapath
//   ALG_SEL    out2 latched algorithm code to the datapath
//   BUSY       out  high in ARM / RUN
//   DONE       out  sticky run-complete flag
//   ERROR      out  sticky failure flag
//   ERR_CODE   out2 0 none, 1 unsupported algorithm, 2 timeout
// -----------------------------------------------------------------------------
module image_proc_ctrl
    import image_proc_ctrl_pkg::*;
#(
    parameter int                  ARM_CYCLES     = 4,
    parameter logic [3:0]          ALG_MASK       = 4'b0001,
    parameter logic [WD_WIDTH-1:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] ALGORITHM,
    input  logic       ACK,
    input  logic       ENG_DONE,
    output logic       ENG_RESET,
    output logic [1:0] ALG_SEL,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic [1:0] ERR_CODE
);

    // The counter is loaded on the IDLE->ARM edge and RUN is entered on the
    // edge where it reads zero, giving exactly ARM_CYCLES cycles in ARM.
    localparam logic [3:0] ARM_LOAD = 4'(ARM_CYCLES - 1);

    state_e     state_q;
    logic [3:0] arm_cnt_q;
    logic [1:0] alg_sel_q;
    logic       eng_reset_q;
    logic       busy_q;
    logic       done_q;
    logic       error_q;
    logic [1:0] err_code_q;

    logic       wd_expire;

`ifdef IPC_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    // Count is held at zero outside RUN so each run starts a fresh window.
    assign wd_enable = (state_q == ST_RUN);
    assign wd_clear  = (state_q != ST_RUN);

    ipc_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expire_o (wd_expire)
    );
`else
    // No watchdog: expiry is constant low; the AND keeps the timeout
    // parameter referenced so both builds share one parameter list.
    assign wd_expire = 1'b0 & (|TIMEOUT_CYCLES);
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            arm_cnt_q   <= '0;
            alg_sel_q   <= '0;
            eng_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    eng_reset_q <= 1'b1;
                    busy_q      <= 1'b0;
                    if (START) begin
                        alg_sel_q <= ALGORITHM;
                        if (alg_supported(ALG_MASK, ALGORITHM)) begin
                            state_q   <= ST_ARM;
                            arm_cnt_q <= ARM_LOAD;
                            busy_q    <= 1'b1;
                        end else begin
                            // Datapath stays in reset: it has no logic
                            // for this code.
                            state_q    <= ST_FAIL;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_UNSUP;
                        end
                    end
                end

                ST_ARM: begin
                    if (arm_cnt_q == 4'd0) begin
                        state_q     <= ST_RUN;
                        eng_reset_q <= 1'b0;
                    end else begin
                        arm_cnt_q <= arm_cnt_q - 4'd1;
                    end
                end

                ST_RUN: begin
                    // Done beats a simultaneous watchdog expiry.
                    if (ENG_DONE) begin
                        state_q     <= ST_CPLT;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        eng_reset_q <= 1'b1;
                    end else if (wd_expire) begin
                        state_q     <= ST_FAIL;
                        error_q     <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                        busy_q      <= 1'b0;
                        eng_reset_q <= 1'b1;
                    end
                end

                ST_CPLT: begin
                    if (ACK) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end

                ST_FAIL: begin
                    if (ACK) begin
                        state_q    <= ST_IDLE;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a safe idle.
                    state_q     <= ST_IDLE;
                    arm_cnt_q   <= '0;
                    eng_reset_q <= 1'b1;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    error_q     <= 1'b0;
                    err_code_q  <= ERR_NONE;
                end
            endcase
        end
    end

    assign ENG_RESET = eng_reset_q;
    assign ALG_SEL   = alg_sel_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERROR     = error_q;
    assign ERR_CODE  = err_code_q;

endmodule

// File: tb/tb_image_proc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_image_proc_ctrl
// Scoreboard bench for image_proc_ctrl: each run pushes its expected final
// report {DONE, ERROR, ERR_CODE, ALG_SEL}; when DONE or ERROR rises the entry
// is popped and compared.  Cycle-exact checks cover latency, reset and
// ignored inputs.  Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_image_proc_ctrl;

    localparam int         ARM = 4;
    localparam logic [3:0] MASK = 4'b0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] algorithm;
    logic       ack;
    logic       eng_done;
    logic       eng_reset;
    logic [1:0] alg_sel;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [1:0] code;
        logic [1:0] alg;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    image_proc_ctrl #(
        .ARM_CYCLES     (ARM),
        .ALG_MASK       (MASK),
        .TIMEOUT_CYCLES (20'd16)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .START     (start),
        .ALGORITHM (algorithm),
        .ACK       (ack),
        .ENG_DONE  (eng_done),
        .ENG_RESET (eng_reset),
        .ALG_SEL   (alg_sel),
        .BUSY      (busy),
        .DONE      (done),
        .ERROR     (error),
        .ERR_CODE  (err_code)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic d, input logic e, input logic [1:0] c, input logic [1:0] a);
        exp_t x;
        x.done = d; x.err = e; x.code = c; x.alg = a;
        return x;
    endfunction

    // Wait (bounded) for DONE or ERROR, then pop and compare the report.
    task automatic wait_result(input string tag, input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            if (!(done || error)) begin
                check_val({tag, "_no_report"}, 32'd0, 32'd1);
            end else begin
                $display("txn %s: done=%0b error=%0b code=%0d alg=%0d busy=%0b eng_reset=%0b",
                         tag, done, error, err_code, alg_sel, busy, eng_reset);
                check_val(tag, {24'd0, done, error, err_code, alg_sel, busy, eng_reset},
                          {24'd0, e.done, e.err, e.code, e.alg, 2'b01});
            end
        end
    endtask

    // Start a supported run and stop at the falling edge of RUN cycle 1,
    // checking that ENG_RESET drops exactly ARM+1 edges after START.
    task automatic to_run(input string tag, input logic [1:0] alg, input logic hold);
        start = 1'b1;
        algorithm = alg;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check_val({tag, "_busy_arm"}, {31'd0, busy}, 32'd1);
        repeat (ARM - 1) @(negedge clk);
        check_val({tag, "_rst_last_arm"}, {31'd0, eng_reset}, 32'd1);
        @(negedge clk);
        check_val({tag, "_rst_low_run"}, {30'd0, eng_reset, busy}, 32'b01);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_val({tag, "_after_ack"}, {26'd0, done, error, err_code, busy, eng_reset},
                  {26'd0, 6'b000001});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic min_rst;

        rst = 1'b1; start = 1'b0; algorithm = 2'd0; ack = 1'b0; eng_done = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset_vals", {24'd0, eng_reset, alg_sel, busy, done, error, err_code},
                  {24'd0, 8'b1_00_0_0_0_00});
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_after_reset", {30'd0, eng_reset, busy}, 32'b10);

        // Basic run: ACK during RUN ignored, ENG_DONE at RUN cycle 10.
        to_run("nn", 2'd0, 1'b0);
        @(negedge clk);                              // RUN cycle 2
        ack = 1'b1;
        @(negedge clk);                              // RUN cycle 3
        ack = 1'b0;
        check_val("nn_ack_in_run", {29'd0, busy, done, eng_reset}, 32'b100);
        repeat (7) @(negedge clk);                   // RUN cycle 10
        check_val("nn_not_done_yet", {31'd0, done}, 32'd0);
        eng_done = 1'b1;
        sb_q.push_back(mk_exp(1'b1, 1'b0, 2'd0, 2'd0));
        @(negedge clk);
        eng_done = 1'b0;
        wait_result("nn_cplt", 0);
        repeat (3) @(negedge clk);
        check_val("nn_cplt_sticky", {31'd0, done}, 32'd1);
        do_ack("nn");

        // Unsupported algorithm: straight to FAIL, datapath never released.
        start = 1'b1; algorithm = 2'd2;
        sb_q.push_back(mk_exp(1'b0, 1'b1, 2'd1, 2'd2));
        @(negedge clk);
        start = 1'b0;
        wait_result("dc_unsup", 0);
        min_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            min_rst = min_rst & eng_reset;
        end
        check_val("dc_eng_reset_held", {31'd0, min_rst}, 32'd1);
        do_ack("dc");

        // Async reset mid-run (RUN cycle 3), no report afterwards.
        to_run("abort", 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("abort_async_vals", {24'd0, eng_reset, alg_sel, busy, done, error, err_code},
                  {24'd0, 8'b1_00_0_0_0_00});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        repeat (3) @(negedge clk);
        check_val("abort_no_report", {28'd0, done, error, busy, eng_reset}, 32'b0001);

        // Reset also clears a latched algorithm and a pending FAIL.
        start = 1'b1; algorithm = 2'd3;
        sb_q.push_back(mk_exp(1'b0, 1'b1, 2'd1, 2'd3));
        @(negedge clk);
        start = 1'b0;
        wait_result("ba_unsup", 0);
        #2 rst = 1'b1;
        #1;
        check_val("ba_reset_clears", {26'd0, alg_sel, error, err_code, done},
                  {26'd0, 6'b00_0_00_0});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Stale ENG_DONE in IDLE/ARM, ALGORITHM changed mid-ARM, START held.
        eng_done = 1'b1;
        repeat (3) @(negedge clk);
        check_val("stale_idle", {30'd0, done, busy}, 32'b00);
        algorithm = 2'd0;
        start = 1'b1;
        @(negedge clk);
        algorithm = 2'd1;
        repeat (ARM - 1) @(negedge clk);
        check_val("stale_arm", {29'd0, done, alg_sel}, {29'd0, 3'b000});
        @(negedge clk);                              // RUN cycle 1
        eng_done = 1'b0;
        check_val("stale_run1", {28'd0, eng_reset, done, alg_sel}, 32'b0000);
        repeat (2) @(negedge clk);
        eng_done = 1'b1;
        sb_q.push_back(mk_exp(1'b1, 1'b0, 2'd0, 2'd0));
        @(negedge clk);
        eng_done = 1'b0;
        wait_result("stale_cplt", 0);
        repeat (2) @(negedge clk);
        check_val("start_in_cplt", {29'd0, done, alg_sel}, {29'd0, 3'b100});
        // ACK with START still high: IDLE first, then a new run (code 1, unsupported).
        do_ack("held");
        sb_q.push_back(mk_exp(1'b0, 1'b1, 2'd1, 2'd1));
        @(negedge clk);
        start = 1'b0;
        wait_result("held_restart", 0);
        do_ack("held_fail");

`ifdef IPC_TIMEOUT_EN
        // Watchdog: no ENG_DONE -> FAIL after RUN cycle 16.
        to_run("wd", 2'd0, 1'b0);
        repeat (15) @(negedge clk);                  // RUN cycle 16
        check_val("wd_cycle16", {29'd0, busy, error, done}, 32'b100);
        sb_q.push_back(mk_exp(1'b0, 1'b1, 2'd2, 2'd0));
        wait_result("wd_timeout", 1);
        do_ack("wd");
        // ENG_DONE on the expiry cycle wins.
        to_run("wdd", 2'd0, 1'b0);
        repeat (15) @(negedge clk);
        eng_done = 1'b1;
        sb_q.push_back(mk_exp(1'b1, 1'b0, 2'd0, 2'd0));
        @(negedge clk);
        eng_done = 1'b0;
        wait_result("wd_done_wins", 0);
        do_ack("wdd");
`else
        // No watchdog: RUN waits indefinitely.
        to_run("long", 2'd0, 1'b0);
        repeat (40) @(negedge clk);
        check_val("long_still_run", {28'd0, busy, error, err_code}, 32'b1000);
        eng_done = 1'b1;
        sb_q.push_back(mk_exp(1'b1, 1'b0, 2'd0, 2'd0));
        @(negedge clk);
        eng_done = 1'b0;
        wait_result("long_cplt", 0);
        do_ack("long");
`endif

        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
